// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, key codes,
// keypad FSM states and small keypad decode helpers.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Key codes: 0-9 digits, A-D operators, then edit keys
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_BKSP = 4'd14;
  localparam logic [3:0] KEY_CLR  = 4'd15;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_HOLD     = 2'd3
  } kp_state_e;

  function automatic logic one_low(input logic [3:0] pat);
    return $countones(~pat) == 1;
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] pat);
    logic [1:0] c;
    case (pat)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      default: c = 2'd3;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] key_code(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    k = 4'd0;
    unique case (1'b1)
      (c == 2'd3):
        k = 4'(KEY_A + {2'b00, r});
      (r == 2'd3 && c == 2'd0):
        k = KEY_BKSP;
      (r == 2'd3 && c == 2'd1):
        k = 4'd0;
      (r == 2'd3 && c == 2'd2):
        k = KEY_CLR;
      default:
        k = 4'({2'b00, r} * 4'd3
             + {2'b00, c} + 4'd1);
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to all ones (idle for active-low lines).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: sync, debounce, and one
// single-cycle key event per press (digit/op/bksp/clr).
module keypad_encoder
  import calc_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       dig_in,
  output logic [3:0] digit,
  output logic       op_in,
  output logic [1:0] op_code,
  output logic       bksp_in,
  output logic       clr_in
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  logic [3:0]    col_s;
  kp_state_e     state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [3:0]    lat_q, lat_d;
  logic          dig_q, dig_d;
  logic          op_q, op_d;
  logic          bk_q, bk_d;
  logic          cl_q, cl_d;
  logic [3:0]    digit_q, digit_d;
  logic [1:0]    opc_q, opc_d;
  logic [3:0]    key;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (col_in),
    .q      (col_s)
  );

  // row_q doubles as the latched row: frozen outside SCAN
  assign key = key_code(row_q, col_idx(lat_q));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_SCAN;
      row_q   <= 2'd0;
      scan_q  <= '0;
      deb_q   <= '0;
      lat_q   <= 4'b1111;
      dig_q   <= 1'b0;
      op_q    <= 1'b0;
      bk_q    <= 1'b0;
      cl_q    <= 1'b0;
      digit_q <= 4'd0;
      opc_q   <= OP_ADD;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      scan_q  <= scan_d;
      deb_q   <= deb_d;
      lat_q   <= lat_d;
      dig_q   <= dig_d;
      op_q    <= op_d;
      bk_q    <= bk_d;
      cl_q    <= cl_d;
      digit_q <= digit_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    scan_d  = scan_q;
    deb_d   = deb_q;
    lat_d   = lat_q;
    dig_d   = 1'b0;
    op_d    = 1'b0;
    bk_d    = 1'b0;
    cl_d    = 1'b0;
    digit_d = digit_q;
    opc_d   = opc_q;
    unique case (state_q)
      ST_SCAN: begin
        if (one_low(col_s)) begin
          lat_d   = col_s;
          deb_d   = '0;
          state_d = ST_DEBOUNCE;
        end else if (scan_q == SCAN_LAST) begin
          scan_d = '0;
          row_d  = row_q + 2'd1;
        end else begin
          scan_d = scan_q + SW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (col_s == lat_q) begin
          if (deb_q == DEB_LAST) begin
            state_d = ST_EMIT;
            unique case (1'b1)
              (key == KEY_BKSP): bk_d = 1'b1;
              (key == KEY_CLR):  cl_d = 1'b1;
              (key >= KEY_A && key < KEY_BKSP): begin
                op_d  = 1'b1;
                opc_d = 2'(key - KEY_A);
              end
              default: begin
                dig_d   = 1'b1;
                digit_d = key;
              end
            endcase
          end else begin
            deb_d = deb_q + DW'(1);
          end
        end else if (col_s != 4'b1111 && one_low(col_s)) begin
          lat_d = col_s;
          deb_d = '0;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_EMIT: begin
        deb_d   = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (col_s != 4'b1111) begin
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          scan_d  = '0;
          state_d = ST_SCAN;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  assign row_out = ~(4'b0001 << row_q);
  assign dig_in  = dig_q;
  assign op_in   = op_q;
  assign bksp_in = bk_q;
  assign clr_in  = cl_q;
  assign digit   = digit_q;
  assign op_code = opc_q;

endmodule
